mmio_timer: RTL

Memory-mapped down-counting timer that acts as a responder on the CPU's RAM-style bus (`txe`/`txs`/`read`/`write`/`addr`/`value`/`out`/`err`). It answers initiator transactions to a 16-byte register window and drives the CPU's `int`/`int_dev_id` interrupt inputs on expiry. It sits beside `ram` on the same bus, behind an address decoder that routes `txs`/`out`/`err` back to the CPU.

---
 rtl/mmio_pkg.sv | 26 ++
 rtl/mmio_responder.sv | 65 ++++++
 rtl/mmio_timer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals on the CPU RAM-style bus:
// register offsets (addr[3:2]), control bit positions and the responder states.
package mmio_pkg;

    // Register offsets within a 16-byte window, selected by addr[3:2]
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_RELOAD = 2;

    // STATUS bit positions
    localparam int STATUS_EXP = 0;

    // Bus responder states, shared by all MMIO peripherals
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } rsp_state_t;

endpackage

// File: rtl/mmio_responder.sv
// Generic responder for the RAM-style bus. Accepts one transaction per txe
// assertion, emits a one-cycle acc strobe on the accept edge, decodes the
// register offset / direction, and produces the txs pulse the cycle after.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [63:0] BASE = 64'h0000_0000_0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txe,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] addr,
    output logic        acc,
    output logic [1:0]  offset,
    output logic        is_rd,
    output logic        is_wr,
    output logic        bad,
    output logic        txs
);

    rsp_state_t state_q;
    rsp_state_t state_d;
    logic       sel;

    assign sel    = (addr[63:4] == BASE[63:4]);
    assign offset = addr[3:2];
    assign is_rd  = read & ~write;
    assign is_wr  = write & ~read;
    // Misaligned, both directions or no direction at all
    assign bad    = (addr[1:0] != 2'b00) | (read == write);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: HOLD waits for txe to drop so a held request is answered once
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (txe && sel) state_d = RESP;
            RESP:    state_d = HOLD;
            HOLD:    if (!txe) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: acc on the accept edge, txs for the whole RESP cycle
    always_comb begin
        acc = 1'b0;
        txs = 1'b0;
        case (state_q)
            IDLE:    acc = txe && sel;
            RESP:    txs = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer. Registers CTRL/LOAD/COUNT/STATUS sit in
// a 16-byte window at BASE. A prescaler divides clk by PRESCALE; each tick
// decrements COUNT and expiry sets STATUS.EXP, optionally reloading.
// The interrupt request output is int_req because "int" is a reserved word.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [63:0] BASE     = 64'h0000_0000_0001_0000,
    parameter logic [7:0]  DEV_ID   = 8'h01,
    parameter int          PRESCALE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        txe,
    input  logic        read,
    input  logic        write,
    input  logic [63:0] addr,
    input  logic [31:0] value,
    output logic        txs,
    output logic [31:0] out,
    output logic        err,
    output logic        int_req,
    output logic [7:0]  int_dev_id
);

    localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);

    logic        acc;
    logic [1:0]  offset;
    logic        is_rd;
    logic        is_wr;
    logic        bad;

    logic        ctrl_en, ctrl_irq_en, ctrl_reload;
    logic [31:0] load_q, count_q;
    logic        exp_q;
    logic [PW-1:0] presc_q;

    logic        en_d, irq_en_d, reload_d, exp_d;
    logic [31:0] load_d, count_d;
    logic [PW-1:0] presc_d;

    logic        acc_err, acc_ok;
    logic        wr_ctrl, wr_load, wr_status;
    logic        tick, expire;
    logic [31:0] rdata;
    logic [31:0] out_p1;
    logic        err_p1;

    mmio_responder #(.BASE(BASE)) u_rsp (
        .clk    (clk),
        .rst    (rst),
        .txe    (txe),
        .read   (read),
        .write  (write),
        .addr   (addr),
        .acc    (acc),
        .offset (offset),
        .is_rd  (is_rd),
        .is_wr  (is_wr),
        .bad    (bad),
        .txs    (txs)
    );

    // COUNT is read-only, so a write to it is rejected like a malformed access
    assign acc_err   = acc & (bad | (is_wr & (offset == TMR_COUNT)));
    assign acc_ok    = acc & ~acc_err;
    assign wr_ctrl   = acc_ok & is_wr & (offset == TMR_CTRL);
    assign wr_load   = acc_ok & is_wr & (offset == TMR_LOAD);
    assign wr_status = acc_ok & is_wr & (offset == TMR_STATUS);

    assign tick   = ctrl_en && (presc_q == PRESC_MAX);
    assign expire = tick && (count_q <= 32'd1);

    // Read mux over the current register values (sampled at the accept edge)
    always_comb begin
        rdata = '0;
        case (offset)
            TMR_CTRL: begin
                rdata[CTRL_EN]     = ctrl_en;
                rdata[CTRL_IRQ_EN] = ctrl_irq_en;
                rdata[CTRL_RELOAD] = ctrl_reload;
            end
            TMR_LOAD:   rdata = load_q;
            TMR_COUNT:  rdata = count_q;
            TMR_STATUS: rdata[STATUS_EXP] = exp_q;
            default:    ;
        endcase
    end

    // Timer next state: counter first, then CPU writes override where allowed
    always_comb begin
        en_d     = ctrl_en;
        irq_en_d = ctrl_irq_en;
        reload_d = ctrl_reload;
        load_d   = load_q;
        count_d  = count_q;
        presc_d  = presc_q;
        exp_d    = exp_q;

        if (ctrl_en) begin
            if (tick) begin
                presc_d = '0;
                if (expire) begin
                    exp_d   = 1'b1;
                    count_d = ctrl_reload ? load_q : 32'd0;
                    if (!ctrl_reload) en_d = 1'b0;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        // W1C loses against a simultaneous expiry
        if (wr_status && value[STATUS_EXP] && !expire) exp_d = 1'b0;

        // A CTRL write overrides an expiry clearing EN in the same cycle
        if (wr_ctrl) begin
            en_d     = value[CTRL_EN];
            irq_en_d = value[CTRL_IRQ_EN];
            reload_d = value[CTRL_RELOAD];
            if (value[CTRL_EN] && !ctrl_en) begin
                count_d = load_q;
                presc_d = '0;
            end
        end

        // LOAD only feeds COUNT on enable or reload, never a running count
        if (wr_load) load_d = value;
    end

    // Timer register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_reload <= 1'b0;
            load_q      <= '0;
            count_q     <= '0;
            presc_q     <= '0;
            exp_q       <= 1'b0;
        end else begin
            ctrl_en     <= en_d;
            ctrl_irq_en <= irq_en_d;
            ctrl_reload <= reload_d;
            load_q      <= load_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            exp_q       <= exp_d;
        end
    end

    // Response data captured on the accept edge, presented during RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_p1 <= '0;
            err_p1 <= 1'b0;
        end else begin
            out_p1 <= (acc_ok && is_rd) ? rdata : 32'd0;
            err_p1 <= acc_err;
        end
    end

    // Interrupt level, one cycle behind EXP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_req <= 1'b0;
        end else begin
            int_req <= exp_q & ctrl_irq_en;
        end
    end

    assign out        = out_p1;
    assign err        = err_p1;
    assign int_dev_id = DEV_ID;

endmodule
